divider32bit_seq: RTL

Sequential unsigned 64/32 divider. It is the inverse of the 32-bit multiplier datapath: it takes a 64-bit product-width dividend and a 32-bit divisor, and returns a 32-bit quotient and a 32-bit remainder. Intended uses are exact checking of multiplier outputs (P / B must give A with remainder 0) and the divide path of the arithmetic unit. It is a radix-2 restoring divider, producing one quotient bit per cycle, with valid/ready handshakes on input and output.

---
 rtl/divider32bit_seq.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/divider32bit_seq.sv
// divider32bit_seq: radix-2 restoring unsigned 64/32 divider, one quotient bit
// per cycle, valid/ready on operands and result.
// Ports: clk, rst (sync, active-high); in_valid/in_ready with N[63:0], D[31:0];
//   out_valid/out_ready with Q, R, div_zero, overflow.
// Build macro DIV_EXACT_EN adds output exact (result is clean: R==0, no flags).
module divider32bit_seq #(
  parameter int N_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] N,
  input  logic [31:0] D,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Q,
  output logic [31:0] R,
  output logic        div_zero,
  output logic        overflow
`ifdef DIV_EXACT_EN
  ,
  output logic        exact
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [4:0] LAST = 5'(N_ITER - 1);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  // Partial remainder stays below D, so bit 32 of the 33-bit
  // remainder is always zero and is not stored.
  logic [31:0] rem_q, rem_d;
  logic [31:0] sh_q, sh_d;
  logic [31:0] d_q, d_d;
  logic [31:0] q_q, q_d;
  logic [31:0] r_q, r_d;
  logic        dz_q, dz_d;
  logic        ov_q, ov_d;
`ifdef DIV_EXACT_EN
  logic        ex_q, ex_d;
`endif

  logic [32:0] t;
  logic [32:0] sub;
  logic        ge;
  logic [31:0] rem_nx;

  // Trial subtraction: t < 2*D, so a set bit 32 in t-D means borrow.
  assign t      = {rem_q, sh_q[31]};
  assign sub    = t - {1'b0, d_q};
  assign ge     = ~sub[32];
  assign rem_nx = ge ? sub[31:0] : t[31:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      sh_q    <= '0;
      d_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
`ifdef DIV_EXACT_EN
      ex_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      sh_q    <= sh_d;
      d_q     <= d_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
`ifdef DIV_EXACT_EN
      ex_q    <= ex_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    sh_d    = sh_q;
    d_d     = d_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
`ifdef DIV_EXACT_EN
    ex_d    = ex_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          d_d = D;
          if (D == 32'd0) begin
            dz_d    = 1'b1;
            ov_d    = 1'b0;
            q_d     = 32'hFFFF_FFFF;
            r_d     = N[31:0];
            state_d = DONE;
          end else if (N[63:32] >= D) begin
            dz_d    = 1'b0;
            ov_d    = 1'b1;
            q_d     = 32'hFFFF_FFFF;
            r_d     = 32'h0;
            state_d = DONE;
          end else begin
            rem_d   = N[63:32];
            sh_d    = N[31:0];
            q_d     = 32'h0;
            cnt_d   = 5'd0;
            state_d = RUN;
          end
`ifdef DIV_EXACT_EN
          ex_d = 1'b0;
`endif
        end
      end
      RUN: begin
        rem_d = rem_nx;
        sh_d  = {sh_q[30:0], 1'b0};
        q_d   = {q_q[30:0], ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST) begin
          r_d     = rem_nx;
          cnt_d   = 5'd0;
          state_d = DONE;
`ifdef DIV_EXACT_EN
          ex_d = (rem_nx == 32'd0);
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          dz_d    = 1'b0;
          ov_d    = 1'b0;
          state_d = IDLE;
`ifdef DIV_EXACT_EN
          ex_d = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Q         = q_q;
  assign R         = r_q;
  assign div_zero  = dz_q;
  assign overflow  = ov_q;
`ifdef DIV_EXACT_EN
  assign exact     = ex_q;
`endif

endmodule
